// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: slot entry, select encoding, select width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_pkg;

    // Slot fields are sized for the widest supported core; narrower tags are zero-extended.
    localparam int FWD_RD_W   = 8;
    localparam int FWD_LAT_W  = 4;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic [FWD_RD_W-1:0]  rd;
        logic [FWD_LAT_W-1:0] lat;
    } fwd_entry_t;

    function automatic int fwd_sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority matcher: youngest matching slot gives the forward select or a hazard.
// Latency: purely combinational.
// Backpressure: none; the hazard output feeds the top-level stall.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = 2
) (
    input  fwd_entry_t             slots [1:DEPTH],
    input  logic [REG_ADDR_W-1:0]  addr,
    input  logic                   used,
    output logic [SEL_W-1:0]       sel,
    output logic                   hazard
);

    logic found;
    int   win;
    int   win_lat;

    always_comb begin
        found   = 1'b0;
        win     = 0;
        win_lat = 0;
        // Scan oldest to youngest so the youngest match is the one left standing.
        for (int k = DEPTH; k >= 1; k--) begin
            if (slots[k].valid && slots[k].rd == FWD_RD_W'(addr)) begin
                found   = 1'b1;
                win     = k;
                win_lat = int'(slots[k].lat);
            end
        end

        sel    = SEL_W'(FWD_SEL_RF);
        hazard = 1'b0;
        if (used && addr != '0 && found) begin
            if (win > win_lat) sel    = SEL_W'(win);
            else               hazard = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit tracking in-flight destination tags in a slot shift register.
// Latency: fwd_sel/stall combinational from slots and id_* inputs; slots update one edge after issue.
// Backpressure: stall holds decode and inserts a bubble; hold freezes all state.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int REG_ADDR_W = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_LAT   = 1,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = fwd_sel_width(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic                          id_regwrite,
    input  logic                          id_is_load,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_count
);

    fwd_entry_t         slots [1:DEPTH];
    fwd_entry_t         new_entry;
    logic [NUM_SRC-1:0] hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .slots  (slots),
            .addr   (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .used   (id_valid & id_src_used[i]),
            .sel    (fwd_sel[i*SEL_W +: SEL_W]),
            .hazard (hazard[i])
        );
    end

    assign stall = |hazard;

    // A stalled instruction is not entered; slot 1 becomes a bubble instead.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = id_valid & ~stall & id_regwrite & (id_rd != '0);
        new_entry.rd    = FWD_RD_W'(id_rd);
        new_entry.lat   = id_is_load ? FWD_LAT_W'(LOAD_LAT) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) slots[k] <= '0;
            stall_count <= '0;
        end else if (flush) begin
            for (int k = 1; k <= DEPTH; k++) slots[k].valid <= 1'b0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) slots[k] <= slots[k-1];
            slots[1] <= new_entry;
            if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
